// File: rtl/mem_arb_pkg.sv
// Shared definitions for the IF/MEM memory-port arbiter.
//   arb_state_e : access sequencer states (IDLE -> ISSUE -> WAIT -> DONE)
//   grant_e     : owner of the current access (fetch or data stage)
//   MAX_MEM_LAT : largest supported fixed read latency
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_D  = 1'b1
    } grant_e;

    localparam int MAX_MEM_LAT = 15;

endpackage

// File: rtl/mem_lat_counter.sv
// Latency counter for one memory access.
//   clk, rst : clock, synchronous active-high reset
//   load     : start of access (ISSUE cycle), counter becomes 1
//   enable   : count up by one (WAIT cycles)
//   done     : counter has reached MEM_LAT-1, access completes next cycle
module mem_lat_counter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic done
);

    // One extra count of headroom: the counter may step once past LAST
    // in the cycle it signals done, and must not wrap back onto it.
    localparam int              CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LAT - 1);

    if (MEM_LAT < 1 || MEM_LAT > MAX_MEM_LAT) begin : g_bad_lat
        $error("mem_lat_counter: MEM_LAT out of range 1..15");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(1);
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF and MEM pipeline stages onto one single-port memory
// with fixed read latency MEM_LAT.
//   clk, rst                    : clock, synchronous active-high reset
//   if_req/if_addr              : fetch request (level, held until if_valid)
//   if_rdata/if_valid           : fetch data and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata   : load/store request (held until d_valid)
//   d_rdata/d_valid             : load data and completion pulse
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata         : memory macro interface
//   stall_f/stall_m             : per-stage stalls to the hazard logic
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_f,
    output logic              stall_m
);

    arb_state_e        state_q, state_d;
    grant_e            owner_q, owner_d;
    grant_e            last_q,  last_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              we_q,    we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              pick_d;
    logic              cnt_load, cnt_en, cnt_done;

    mem_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
        .clk    (clk),
        .rst    (rst),
        .load   (cnt_load),
        .enable (cnt_en),
        .done   (cnt_done)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        // Data wins alone, or on contention when fetch had the last turn.
        pick_d   = d_req && (!if_req || last_q == GRANT_IF);
        unique case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    owner_d = pick_d ? GRANT_D : GRANT_IF;
                    last_d  = pick_d ? GRANT_D : GRANT_IF;
                    addr_d  = pick_d ? d_addr : if_addr;
                    we_d    = pick_d && d_we;
                    wdata_d = pick_d ? d_wdata : '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_load = 1'b1;
                state_d  = (MEM_LAT == 1) ? DONE : WAIT;
            end
            WAIT: begin
                cnt_en = 1'b1;
                if (cnt_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= GRANT_IF;
            last_q  <= GRANT_IF;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    // The captured request drives the macro from ISSUE through DONE;
    // mem_en itself is a straight decode of the ISSUE state.
    assign mem_en    = (state_q == ISSUE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_valid  = (state_q == DONE) && (owner_q == GRANT_IF);
    assign d_valid   = (state_q == DONE) && (owner_q == GRANT_D);
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

    assign stall_f   = if_req && !if_valid;
    assign stall_m   = d_req  && !d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int          LAT = 2;
    localparam logic [31:0] BAD = 32'h0BAD_0BAD;

    typedef struct {
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_exp_t;

    typedef struct {
        int          cyc;
        logic        is_d;
        logic        chkd;
        logic [31:0] data;
    } resp_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    // MEM_LAT=2 instance, scoreboard-checked
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_valid, d_valid, mem_en, mem_we, stall_f, stall_m;

    // MEM_LAT=1 instance, checked directly
    logic        if1_req = 1'b0, d1_req = 1'b0, d1_we = 1'b0;
    logic [31:0] if1_addr = '0, d1_addr = '0, d1_wdata = '0;
    logic [31:0] if1_rdata, d1_rdata, mem1_addr, mem1_wdata, mem1_rdata;
    logic        if1_valid, d1_valid, mem1_en, mem1_we, stall1_f, stall1_m;

    mem_exp_t  exp_mem[$];
    resp_exp_t exp_resp[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_f(stall_f), .stall_m(stall_m)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(if1_req), .if_addr(if1_addr), .if_rdata(if1_rdata), .if_valid(if1_valid),
        .d_req(d1_req), .d_we(d1_we), .d_addr(d1_addr), .d_wdata(d1_wdata),
        .d_rdata(d1_rdata), .d_valid(d1_valid),
        .mem_en(mem1_en), .mem_we(mem1_we), .mem_addr(mem1_addr),
        .mem_wdata(mem1_wdata), .mem_rdata(mem1_rdata),
        .stall_f(stall1_f), .stall_m(stall1_m)
    );

    // Memory contents: one special word, otherwise an address-derived pattern.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Fixed-latency memory models; data outside the response cycle is garbage.
    logic [LAT-1:0] pv = '0;
    logic [31:0]    pa [LAT];
    always @(posedge clk) begin
        pv    <= {pv[LAT-2:0], mem_en};
        pa[0] <= mem_addr;
        for (int i = 1; i < LAT; i++) pa[i] <= pa[i-1];
    end
    assign mem_rdata = pv[LAT-1] ? mem_fn(pa[LAT-1]) : BAD;

    logic        m1_v = 1'b0;
    logic [31:0] m1_a = '0;
    always @(posedge clk) begin
        m1_v <= mem1_en;
        m1_a <= mem1_addr;
    end
    assign mem1_rdata = m1_v ? mem_fn(m1_a) : BAD;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Push the expected issue and completion of one access requested in cycle c.
    task automatic exp_acc(input int c, input logic is_d, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic chkd);
        mem_exp_t  me;
        resp_exp_t re;
        me.cyc = c + 1; me.we = we; me.addr = addr; me.data = wdata;
        re.cyc = c + 1 + LAT; re.is_d = is_d; re.chkd = chkd; re.data = mem_fn(addr);
        exp_mem.push_back(me);
        exp_resp.push_back(re);
    endtask

    // Monitor: every memory strobe and every completion pops one expectation.
    always @(negedge clk) begin : mon
        mem_exp_t  me;
        resp_exp_t re;
        if (mem_en === 1'b1) begin
            if (exp_mem.size() == 0) begin
                chk1("mem_en unexpected", mem_en, 1'b0);
            end else begin
                me = exp_mem.pop_front();
                chk("mem_en cycle", cyc, me.cyc);
                chk1("mem_we", mem_we, me.we);
                chk("mem_addr", mem_addr, me.addr);
                if (me.we) chk("mem_wdata", mem_wdata, me.data);
            end
        end
        if (if_valid === 1'b1 || d_valid === 1'b1) begin
            if (exp_resp.size() == 0) begin
                chk1("if_valid unexpected", if_valid, 1'b0);
                chk1("d_valid unexpected", d_valid, 1'b0);
            end else begin
                re = exp_resp.pop_front();
                chk("valid cycle", cyc, re.cyc);
                chk1("valid owner d", d_valid, re.is_d);
                chk1("valid owner if", if_valid, !re.is_d);
                if (re.chkd) chk("rdata", re.is_d ? d_rdata : if_rdata, re.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;

        // Reset held two cycles with both requests asserted.
        rst = 1'b1; if_req = 1'b1; d_req = 1'b1;
        if_addr = 32'h80; d_addr = 32'h40; d_we = 1'b0;
        repeat (2) begin
            step();
            chk1("rst mem_en", mem_en, 1'b0);
            chk1("rst if_valid", if_valid, 1'b0);
            chk1("rst d_valid", d_valid, 1'b0);
            chk("rst mem_addr", mem_addr, 32'h0);
        end
        rst = 1'b0;
        c = cyc;
        exp_acc(c, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1);
        exp_acc(c + 4, 1'b0, 1'b0, 32'h80, 32'h0, 1'b1);
        repeat (4) step();
        d_req = 1'b0;
        repeat (4) step();
        if_req = 1'b0;

        // Single fetch with stall_f profile.
        step();
        c = cyc;
        if_req = 1'b1; if_addr = 32'h100;
        exp_acc(c, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1);
        #1 chk1("fetch stall_f c0", stall_f, 1'b1);
        step(); chk1("fetch stall_f c1", stall_f, 1'b1);
        step(); chk1("fetch stall_f c2", stall_f, 1'b1);
        step(); chk1("fetch stall_f c3", stall_f, 1'b0);
        step(); if_req = 1'b0;

        // Simultaneous store and fetch after reset: data first.
        step();
        do_reset();
        c = cyc;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h55;
        if_req = 1'b1; if_addr = 32'h104;
        exp_acc(c, 1'b1, 1'b1, 32'h200, 32'h55, 1'b0);
        exp_acc(c + 4, 1'b0, 1'b0, 32'h104, 32'h0, 1'b1);
        #1 chk1("store stall_m c0", stall_m, 1'b1);
        repeat (4) step();
        d_req = 1'b0; d_we = 1'b0;
        repeat (2) step();
        chk1("contend stall_f c6", stall_f, 1'b1);
        step();
        chk1("contend stall_f c7", stall_f, 1'b0);
        step();
        if_req = 1'b0;

        // Sustained contention: strict D,I,D,I alternation.
        step();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            if_addr = 32'h1000 + 32'(16 * k);
            d_addr  = 32'h2000 + 32'(16 * k);
            if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
            exp_acc(cyc, (k % 2) == 0, 1'b0, ((k % 2) == 0) ? d_addr : if_addr, 32'h0, 1'b1);
            repeat (4) step();
        end
        if_req = 1'b0; d_req = 1'b0;

        // Reset mid-access: the abandoned fetch never completes.
        step();
        c = cyc;
        if_req = 1'b1; if_addr = 32'h180;
        begin
            mem_exp_t me;
            me.cyc = c + 1; me.we = 1'b0; me.addr = 32'h180; me.data = 32'h0;
            exp_mem.push_back(me);
        end
        step();
        step();
        rst = 1'b1; if_req = 1'b0;
        step();
        rst = 1'b0;
        chk1("abandon mem_en", mem_en, 1'b0);
        chk1("abandon if_valid", if_valid, 1'b0);
        if_req = 1'b1; if_addr = 32'h1C0;
        exp_acc(cyc, 1'b0, 1'b0, 32'h1C0, 32'h0, 1'b1);
        repeat (4) step();
        if_req = 1'b0;

        // MEM_LAT=1 instance: load then fetch at minimum spacing.
        step();
        d1_req = 1'b1; d1_we = 1'b0; d1_addr = 32'h300;
        step();
        chk1("lat1 mem_en c1", mem1_en, 1'b1);
        chk("lat1 mem_addr c1", mem1_addr, 32'h300);
        chk1("lat1 mem_we c1", mem1_we, 1'b0);
        if1_req = 1'b1; if1_addr = 32'h304;
        step();
        chk1("lat1 d_valid c2", d1_valid, 1'b1);
        chk("lat1 d_rdata c2", d1_rdata, mem_fn(32'h300));
        chk1("lat1 if_valid c2", if1_valid, 1'b0);
        step();
        d1_req = 1'b0;
        chk1("lat1 mem_en c3", mem1_en, 1'b0);
        step();
        chk1("lat1 mem_en c4", mem1_en, 1'b1);
        chk("lat1 mem_addr c4", mem1_addr, 32'h304);
        step();
        chk1("lat1 if_valid c5", if1_valid, 1'b1);
        chk("lat1 if_rdata c5", if1_rdata, mem_fn(32'h304));
        step();
        if1_req = 1'b0;

        repeat (10) step();
        chk("mem queue drained", exp_mem.size(), 32'd0);
        chk("resp queue drained", exp_resp.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
